// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 shifter, ALU with NZCV, branch target, and the EX/MEM register.
// Define EXE_FORWARDING_EN to enable the forwarding muxes on op1/rm; otherwise the raw register operands are used.
module exe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             wb_en_in,
   input  logic             mem_r_en_in,
   input  logic             mem_w_en_in,
   input  logic             b_in,
   input  logic             s_in,
   input  logic [3:0]       exe_cmd,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] val_rn_in,
   input  logic [WIDTH-1:0] val_rm_in,
   input  logic             imm_in,
   input  logic [11:0]      shift_operand,
   input  logic [23:0]      signed_imm_24,
   input  logic [3:0]       dest_in,
   input  logic [3:0]       sr_in,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] mem_fwd_val,
   input  logic [WIDTH-1:0] wb_fwd_val,
   output logic             branch_taken,
   output logic [WIDTH-1:0] branch_addr,
   output logic [3:0]       status,
   output logic             wb_en,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic [WIDTH-1:0] alu_res,
   output logic [WIDTH-1:0] st_val,
   output logic [3:0]       dest
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;

   logic [WIDTH-1:0] w_op1;
   logic [WIDTH-1:0] w_rm;
   logic [WIDTH-1:0] w_val2;
   logic [WIDTH-1:0] w_imm_base;
   logic [WIDTH-1:0] w_imm_val;
   logic [5:0]       w_imm_rot;
   logic [5:0]       w_imm_rot_inv;
   logic [5:0]       w_sh_amt;
   logic [5:0]       w_sh_amt_inv;
   logic [WIDTH-1:0] w_rm_shifted;
   logic [WIDTH-1:0] w_add_b;
   logic             w_add_cin;
   logic             w_is_arith;
   logic             w_is_sub;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_c;
   logic             w_v;
   logic [3:0]       w_flags;
   logic             w_unused_sr;

   logic [3:0]       r_status;
   logic             r_wb_en;
   logic             r_mem_r_en;
   logic             r_mem_w_en;
   logic [WIDTH-1:0] r_alu_res;
   logic [WIDTH-1:0] r_st_val;
   logic [3:0]       r_dest;

   // Only C and V of the carried snapshot feed the ALU; N/Z are always recomputed.
   assign w_unused_sr = ^sr_in[3:2];

`ifdef EXE_FORWARDING_EN
   always_comb begin
      case (sel_src1)
         2'b01:   w_op1 = mem_fwd_val;
         2'b10:   w_op1 = wb_fwd_val;
         default: w_op1 = val_rn_in;
      endcase
      case (sel_src2)
         2'b01:   w_rm = mem_fwd_val;
         2'b10:   w_rm = wb_fwd_val;
         default: w_rm = val_rm_in;
      endcase
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
   assign w_op1 = val_rn_in;
   assign w_rm  = val_rm_in;
`endif

   // Rotate-right is built from two opposing shifts; a shift by WIDTH yields zero, so rotate-by-0 is identity.
   assign w_imm_base    = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
   assign w_imm_rot     = {1'b0, shift_operand[11:8], 1'b0};
   assign w_imm_rot_inv = 6'(WIDTH) - w_imm_rot;
   assign w_imm_val     = (w_imm_base >> w_imm_rot) | (w_imm_base << w_imm_rot_inv);

   assign w_sh_amt     = {1'b0, shift_operand[11:7]};
   assign w_sh_amt_inv = 6'(WIDTH) - w_sh_amt;

   always_comb begin
      case (shift_operand[6:5])
         SH_LSL:  w_rm_shifted = w_rm << w_sh_amt;
         SH_LSR:  w_rm_shifted = w_rm >> w_sh_amt;
         SH_ASR:  w_rm_shifted = $signed(w_rm) >>> w_sh_amt;
         default: w_rm_shifted = (w_rm >> w_sh_amt) | (w_rm << w_sh_amt_inv);
      endcase
   end

   always_comb begin
      if (mem_r_en_in || mem_w_en_in) begin
         w_val2 = {{(WIDTH-12){1'b0}}, shift_operand};
      end else if (imm_in) begin
         w_val2 = w_imm_val;
      end else begin
         w_val2 = w_rm_shifted;
      end
   end

   // One shared adder: subtraction is op1 + ~val2 + carry-in, so the carry out is NOT borrow.
   always_comb begin
      w_add_b    = w_val2;
      w_add_cin  = 1'b0;
      w_is_arith = 1'b1;
      w_is_sub   = 1'b0;
      case (exe_cmd)
         CMD_ADD: begin
            w_add_b   = w_val2;
            w_add_cin = 1'b0;
         end
         CMD_ADC: begin
            w_add_b   = w_val2;
            w_add_cin = sr_in[1];
         end
         CMD_SUB: begin
            w_add_b   = ~w_val2;
            w_add_cin = 1'b1;
            w_is_sub  = 1'b1;
         end
         CMD_SBC: begin
            w_add_b   = ~w_val2;
            w_add_cin = sr_in[1];
            w_is_sub  = 1'b1;
         end
         default: w_is_arith = 1'b0;
      endcase
   end

   assign w_sum = {1'b0, w_op1} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};

   always_comb begin
      w_alu_res = '0;
      w_c       = sr_in[1];
      w_v       = sr_in[0];
      case (exe_cmd)
         CMD_MOV: w_alu_res = w_val2;
         CMD_MVN: w_alu_res = ~w_val2;
         CMD_AND: w_alu_res = w_op1 & w_val2;
         CMD_ORR: w_alu_res = w_op1 | w_val2;
         CMD_EOR: w_alu_res = w_op1 ^ w_val2;
         default: w_alu_res = '0;
      endcase
      if (w_is_arith) begin
         w_alu_res = w_sum[WIDTH-1:0];
         w_c       = w_sum[WIDTH];
         if (w_is_sub) begin
            w_v = (w_op1[WIDTH-1] != w_val2[WIDTH-1]) && (w_sum[WIDTH-1] != w_op1[WIDTH-1]);
         end else begin
            w_v = (w_op1[WIDTH-1] == w_val2[WIDTH-1]) && (w_sum[WIDTH-1] != w_op1[WIDTH-1]);
         end
      end
   end

   assign w_flags = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_c, w_v};

   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= '0;
      end else if (!freeze && s_in) begin
         r_status <= w_flags;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= '0;
         r_st_val   <= '0;
         r_dest     <= '0;
      end else if (!freeze) begin
         r_wb_en    <= wb_en_in;
         r_mem_r_en <= mem_r_en_in;
         r_mem_w_en <= mem_w_en_in;
         r_alu_res  <= w_alu_res;
         r_st_val   <= w_rm;
         r_dest     <= dest_in;
      end
   end

   assign status   = r_status;
   assign wb_en    = r_wb_en;
   assign mem_r_en = r_mem_r_en;
   assign mem_w_en = r_mem_w_en;
   assign alu_res  = r_alu_res;
   assign st_val   = r_st_val;
   assign dest     = r_dest;

endmodule
